// File: rtl/dual_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dual_core_mem_arbiter
//
// Lets two processor cores share one single-port synchronous data memory.
// Requests are serialised with round-robin arbitration. Each transaction runs
// IDLE -> ISSUE -> (WAIT ->) RESP -> IDLE. The requesting core gets a one-cycle
// acknowledge, with read data for reads, in the cycle after RESP.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     asynchronous active-low reset
//   req0/1    core request, held with we/addr/wdata stable until ack
//   we0/1     1 = write, 0 = read
//   addr0/1   core address (AW bits)
//   wdata0/1  core write data (DW bits)
//   ack0/1    one-cycle completion pulse to the core
//   rdata0/1  core read data, valid with ack and held afterwards
//   mem_addr  registered memory address
//   mem_data  registered memory write data
//   mem_wren  registered memory write enable, high for the ISSUE cycle only
//   mem_q     memory read data
//   busy      high while the FSM is outside IDLE
//   grant     index of the core currently or last served
// -----------------------------------------------------------------------------
module dual_core_mem_arbiter #(
   parameter int unsigned DW       = 12,
   parameter int unsigned AW       = 12,
   parameter int unsigned READ_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,

   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_wren,
   input  logic [DW-1:0] mem_q,

   output logic          busy,
   output logic          grant
);

   // Latency counter wide enough for READ_LAT-1 with READ_LAT in 1..3.
   localparam int unsigned CW = 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]    state,     state_nxt;
   logic [CW-1:0] lat_cnt,   lat_cnt_nxt;
   // Index of the core served most recently; the other core wins a tie.
   logic          rr_last,   rr_last_nxt;

   logic [AW-1:0] mem_addr_nxt;
   logic [DW-1:0] mem_data_nxt;
   logic          mem_wren_nxt;
   logic [DW-1:0] rdata0_nxt, rdata1_nxt;
   logic          ack0_nxt,   ack1_nxt;
   logic          busy_nxt;
   logic          grant_nxt;
   logic          win;

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         rr_last  <= 1'b1;
         mem_addr <= '0;
         mem_data <= '0;
         mem_wren <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         grant    <= 1'b0;
      end else begin
         state    <= state_nxt;
         lat_cnt  <= lat_cnt_nxt;
         rr_last  <= rr_last_nxt;
         mem_addr <= mem_addr_nxt;
         mem_data <= mem_data_nxt;
         mem_wren <= mem_wren_nxt;
         rdata0   <= rdata0_nxt;
         rdata1   <= rdata1_nxt;
         ack0     <= ack0_nxt;
         ack1     <= ack1_nxt;
         busy     <= busy_nxt;
         grant    <= grant_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state;
      lat_cnt_nxt  = lat_cnt;
      rr_last_nxt  = rr_last;
      mem_addr_nxt = mem_addr;
      mem_data_nxt = mem_data;
      mem_wren_nxt = mem_wren;
      rdata0_nxt   = rdata0;
      rdata1_nxt   = rdata1;
      ack0_nxt     = 1'b0;
      ack1_nxt     = 1'b0;
      grant_nxt    = grant;
      win          = 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // Sole requester wins; on a tie the core not served last wins.
               win          = (req0 && req1) ? ~rr_last : req1;
               grant_nxt    = win;
               mem_addr_nxt = win ? addr1  : addr0;
               mem_data_nxt = win ? wdata1 : wdata0;
               mem_wren_nxt = win ? we1    : we0;
               state_nxt    = ISSUE;
            end
         end

         ISSUE: begin
            // mem_wren still holds the latched we during this cycle.
            mem_wren_nxt = 1'b0;
            if (mem_wren) begin
               state_nxt = RESP;
            end else begin
               lat_cnt_nxt = CW'(READ_LAT - 1);
               state_nxt   = WAIT;
            end
         end

         WAIT: begin
            if (lat_cnt == '0) begin
               if (grant) rdata1_nxt = mem_q;
               else       rdata0_nxt = mem_q;
               state_nxt = RESP;
            end else begin
               lat_cnt_nxt = lat_cnt - 1'b1;
            end
         end

         RESP: begin
            // Ack registers out of RESP, so it is visible in the following cycle.
            ack0_nxt    = ~grant;
            ack1_nxt    = grant;
            rr_last_nxt = grant;
            state_nxt   = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
- Memory-side responder that lets two processor cores share one single-port synchronous data memory (MemoryQ-style).
- Sits between the cores' memory-request outputs and the memory's address/data/wren/q pins.
- Serialises requests with round-robin arbitration, drives the memory, and returns one-cycle acknowledges with read data to the requesting core.

Parameters:
- DW, 12, data width (matches core reg_width).
- AW, 12, memory address width.
- READ_LAT, 1, memory read latency in clocks from address sampled to q valid (1..3).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  core0 request; held high, with addr0/we0/wdata0 stable, until ack0.
- we0  input  1  core0: 1 = write, 0 = read.
- addr0  input  AW  core0 address.
- wdata0  input  DW  core0 write data.
- ack0  output  1  one-cycle completion pulse to core0.
- rdata0  output  DW  core0 read data; valid while ack0=1, held afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for core1.
- mem_addr  output  AW  registered address to memory.
- mem_data  output  DW  registered write data to memory.
- mem_wren  output  1  registered write enable to memory.
- mem_q  input  DW  memory read data.
- busy  output  1  high in any state other than IDLE.
- grant  output  1  index of the core currently or last served.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - ack0, ack1, mem_wren, busy, grant = 0.
  - mem_addr, mem_data, rdata0, rdata1 = 0.
  - Round-robin pointer set so core0 wins the first tie.
  - An in-flight transaction is discarded; no ack is issued. mem_wren must drop immediately.
- State machine: IDLE -> ISSUE -> (WAIT ->) RESP -> IDLE.
- IDLE:
  - If any reqX=1, choose the winner: the only requester, or on a tie the core not served last.
  - Latch winner's addr/wdata/we into mem_addr/mem_data/mem_wren(=we). Set grant. Go to ISSUE.
- ISSUE (one cycle; memory samples mem_* at the closing edge):
  - mem_wren is deasserted at the closing edge.
  - Write: go to RESP.
  - Read: load the latency counter with READ_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it is 0, capture mem_q into rdataX of the granted core. Go to RESP.
- RESP (one cycle):
  - ackX=1 for the granted core only. busy stays high.
  - Update the round-robin pointer. Go to IDLE.
- Latency, with req sampled at edge N:
  - Write: memory write at edge N+1; ack high during the cycle after edge N+2.
  - Read: ack high during the cycle after edge N+2+READ_LAT.
  - Minimum throughput: write every 3 cycles, read every 3+READ_LAT cycles.
- Back-to-back requests:
  - A req still high in the IDLE cycle after its ack is a new request.
  - If the other core is also requesting, the other core wins.
- req is sampled only in IDLE. Dropping req before ack is a protocol violation; the latched transaction still completes and acks.
- Never both ack0 and ack1 in the same cycle. The non-granted core's rdata is unchanged.
- Address and data are passed through unmodified; no width conversion.

Test Plan:
- Reset check: hold reset=0 with req0=1 -> all outputs 0, no mem_wren. Release -> service starts at the next edge.
- Single write: core0 writes addr 0x005, data 0xABC -> mem_wren=1 with mem_addr=0x005, mem_data=0xABC for exactly one cycle; ack0 pulses 2 cycles after IDLE sample; ack1 stays 0.
- Single read (READ_LAT=1): model memory returns 0x123 for addr 0x005; core1 reads 0x005 -> rdata1=0x123 with ack1 3 cycles after sample; rdata0 unchanged.
- Tie: req0=req1=1 from reset -> core0 served first, then core1. Both held high -> strict alternation 0,1,0,1 over 4 transactions.
- Write-then-read coherence: core0 writes 0x7FF to addr 0x010, then core1 reads 0x010 -> rdata1=0x7FF.
- Reset mid-read: assert reset during WAIT -> no ack, rdata cleared. The next request after release completes normally.
